conv_ctrl: RTL and testbench
============================

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameter m, default 6, pixel RAM address width.
REQ-002 Parameter p, default 5, image side length: the image is p x p pixels, with p*p <= 2^m.
REQ-003 Parameter TW, default 8, watchdog counter width; used only when CONV_CTRL_TIMEOUT_EN is defined.
REQ-004 clk  input  1  the single clock; every register updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low: the block is in reset while rst=0 at a rising clk edge.
REQ-006 start  input  1  one-cycle request to begin a convolution frame.
REQ-007 ext_wr  input  1  host pixel write strobe.
REQ-008 ext_adr  input  m  host pixel write address.
REQ-009 donemult  input  1  the sequential MAC has finished its current window.
REQ-010 load  output  1  kernel register load strobe.
REQ-011 init0  output  1  clears the shift-register chain to zero.
REQ-012 sh  output  1  shift enable for the window chain.
REQ-013 sel0  output  1  selects the zero padding value into the chain.
REQ-014 selpix  output  1  selects the RAM pixel into the chain.
REQ-015 rd_inram  output  1  RAM read enable.
REQ-016 wr_inram  output  1  RAM write enable.
REQ-017 pixadr  output  m  RAM address.
REQ-018 startmult  output  1  one-cycle MAC start pulse.
REQ-019 out_valid  output  1  the MAC result is valid for out_adr.
REQ-020 out_adr  output  m  output pixel index of the current result.
REQ-021 busy  output  1  high whenever the state is not IDLE.
REQ-022 done  output  1  one-cycle end-of-frame pulse.
REQ-023 err  output  1  sticky watchdog error flag.

Function
REQ-024 States SHALL be: IDLE, LOAD, CLEAR, STREAM, MULT, WAIT, EMIT, DONE.
REQ-025 In IDLE: wr_inram=ext_wr; pixadr=ext_adr; start moves the state to LOAD; all other strobes are 0.
REQ-026 In every state other than IDLE: ext_wr and ext_adr are ignored, wr_inram=0, and start is ignored.
REQ-027 LOAD and CLEAR each last one cycle and move to the next state unconditionally.
REQ-028 In LOAD: load=1. In CLEAR: init0=1. Entering LOAD also resets the stream index k=0.
REQ-029 STREAM shifts one padded pixel per cycle (sh=1).
- The padded frame is (p+2)x(p+2); k runs 0..(p+2)^2-1.
- Padded coordinates: r=k/(p+2), c=k%(p+2).
REQ-030 Border pixel (r or c equal to 0 or p+1): sel0=1, selpix=0, rd_inram=0.
REQ-031 Interior pixel: selpix=1, sel0=0, rd_inram=1, pixadr=(r-1)*p+(c-1). The RAM read is combinational and the pixel is captured by the same shift.
REQ-032 After shifting k, a window is valid iff r>=2 and c>=2. A valid window moves the state to MULT; otherwise k increments and STREAM continues.
REQ-033 MULT lasts one cycle: startmult=1, sh=0, then the state moves to WAIT.
REQ-034 WAIT holds all strobes at 0 until donemult=1, then moves to EMIT.
- donemult is sampled only from the first WAIT cycle onward.
- donemult in any other state is ignored.
REQ-035 EMIT lasts one cycle: out_valid=1, out_adr=(r-2)*p+(c-2) for the latched k.
- If k is the last index, the state moves to DONE.
- Otherwise k increments and the state returns to STREAM.
REQ-036 DONE lasts one cycle: done=1, then the state moves to IDLE.
REQ-037 Per frame: exactly (p+2)^2 sh pulses, p*p startmult pulses and p*p out_valid pulses, with out_adr ascending from 0 to p*p-1.
REQ-038 start asserted in the same cycle as DONE is ignored; a frame requires start while in IDLE.

Reset
REQ-039 While rst=0 at a clock edge: state goes to IDLE, k=0, the watchdog clears, err=0.
REQ-040 While rst=0 at a clock edge: all outputs are 0 on the following cycle, including when this happens mid-frame in any state.

Configuration
REQ-041 With CONV_CTRL_TIMEOUT_EN defined: a TW-bit counter counts WAIT cycles.
- If the count reaches 2^TW-1 without donemult, err sets to 1 and the state moves to DONE, abandoning the frame.
- err stays 1 until reset or the next LOAD.
REQ-042 Without CONV_CTRL_TIMEOUT_EN: there is no counter, err is tied to 0, and WAIT persists indefinitely.

Verification
REQ-043 p=5, m=6, MAC model with donemult 3 cycles after startmult, start at cycle 0 -> load at cycle 1, init0 at cycle 2, shifts k=0..16 at cycles 3..19, first startmult at cycle 20, first out_valid with out_adr=0.
REQ-044 Same frame -> 49 sh pulses, 24 with sel0=1, 25 with pixadr 0..24 ascending, 25 out_valid with out_adr 0..24, then one done pulse.
REQ-045 In IDLE drive ext_wr=1, ext_adr=7 -> wr_inram=1, pixadr=7; drive the same during STREAM -> wr_inram=0.
REQ-046 rst=0 during WAIT of window 10 -> next cycle state IDLE and all outputs 0; a following start runs a complete 25-window frame.
REQ-047 CONV_CTRL_TIMEOUT_EN with TW=4 and donemult never asserted -> err=1 and done=1 after 15 WAIT cycles, then IDLE; without the macro -> busy stays 1 and err=0.

Source files
------------

// File: rtl/conv_ctrl.sv
// Control FSM for a 3x3 zero-padded convolution over a p x p pixel RAM image.
// Define CONV_CTRL_TIMEOUT_EN to add a WAIT-state watchdog that raises a sticky err.
module conv_ctrl #(
    parameter int m  = 6,
    parameter int p  = 5,
    parameter int TW = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         ext_wr,
    input  logic [m-1:0] ext_adr,
    input  logic         donemult,
    output logic         load,
    output logic         init0,
    output logic         sh,
    output logic         sel0,
    output logic         selpix,
    output logic         rd_inram,
    output logic         wr_inram,
    output logic [m-1:0] pixadr,
    output logic         startmult,
    output logic         out_valid,
    output logic [m-1:0] out_adr,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [m-1:0] ZERO_M = '0;
    localparam logic [m-1:0] ONE_M  = m'(1);
    localparam logic [m-1:0] TWO_M  = m'(2);
    localparam logic [m-1:0] P_M    = m'(p);
    localparam logic [m-1:0] LAST_M = m'(p + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_STREAM, S_MULT, S_WAIT, S_EMIT, S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [m-1:0] row_q, row_d, col_q, col_d;
    logic [m-1:0] row_nx_s, col_nx_s, pix_adr_s, win_adr_s;
    logic         border_s, win_valid_s, last_s;

    // The stream index k is kept as padded (row, col) so no divider is needed.
    assign border_s    = (row_q == ZERO_M) || (row_q == LAST_M) ||
                         (col_q == ZERO_M) || (col_q == LAST_M);
    assign win_valid_s = (row_q >= TWO_M) && (col_q >= TWO_M);
    assign last_s      = (row_q == LAST_M) && (col_q == LAST_M);
    assign pix_adr_s   = (row_q - ONE_M) * P_M + (col_q - ONE_M);
    assign win_adr_s   = (row_q - TWO_M) * P_M + (col_q - TWO_M);

    // Raster-order successor of the current padded coordinate.
    always_comb begin
        if (col_q == LAST_M) begin
            row_nx_s = row_q + ONE_M;
            col_nx_s = ZERO_M;
        end else begin
            row_nx_s = row_q;
            col_nx_s = col_q + ONE_M;
        end
    end

`ifdef CONV_CTRL_TIMEOUT_EN
    localparam logic [TW-1:0] WDOG_TRIP = {{(TW-1){1'b1}}, 1'b0};

    logic [TW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
    logic          wdog_trip_s;

    assign wdog_trip_s = (wdog_q == WDOG_TRIP);
    assign err         = err_q;

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
`else
    logic [TW-1:0] unused_wdog_s;

    assign unused_wdog_s = '0;
    assign err           = 1'b0;
`endif

    // State and stream-position registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            row_q   <= ZERO_M;
            col_q   <= ZERO_M;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next-state and stream-position update.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
`ifdef CONV_CTRL_TIMEOUT_EN
        wdog_d  = '0;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    row_d   = ZERO_M;
                    col_d   = ZERO_M;
`ifdef CONV_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD:  state_d = S_CLEAR;
            S_CLEAR: state_d = S_STREAM;
            S_STREAM: begin
                if (win_valid_s) begin
                    state_d = S_MULT;
                end else begin
                    row_d = row_nx_s;
                    col_d = col_nx_s;
                end
            end
            S_MULT:  state_d = S_WAIT;
            S_WAIT: begin
`ifdef CONV_CTRL_TIMEOUT_EN
                if (donemult) begin
                    state_d = S_EMIT;
                end else if (wdog_trip_s) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_q + TW'(1);
                end
`else
                if (donemult) begin
                    state_d = S_EMIT;
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_EMIT: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM;
                    row_d   = row_nx_s;
                    col_d   = col_nx_s;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode; only IDLE forwards the host write port.
    always_comb begin
        load      = 1'b0;
        init0     = 1'b0;
        sh        = 1'b0;
        sel0      = 1'b0;
        selpix    = 1'b0;
        rd_inram  = 1'b0;
        wr_inram  = 1'b0;
        pixadr    = ZERO_M;
        startmult = 1'b0;
        out_valid = 1'b0;
        out_adr   = ZERO_M;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                wr_inram = ext_wr;
                pixadr   = ext_adr;
            end
            S_LOAD:  load  = 1'b1;
            S_CLEAR: init0 = 1'b1;
            S_STREAM: begin
                sh = 1'b1;
                if (border_s) begin
                    sel0 = 1'b1;
                end else begin
                    selpix   = 1'b1;
                    rd_inram = 1'b1;
                    pixadr   = pix_adr_s;
                end
            end
            S_MULT:  startmult = 1'b1;
            S_WAIT:  busy      = 1'b1;
            S_EMIT: begin
                out_valid = 1'b1;
                out_adr   = win_adr_s;
            end
            S_DONE:  done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed self-checking bench for conv_ctrl (p=5, m=6, TW=4) with a 3-cycle MAC model.
module tb_conv_ctrl;

    localparam int M  = 6;
    localparam int P  = 5;
    localparam int TW = 4;

    logic         clk = 1'b0;
    logic         rst, start, ext_wr;
    logic [M-1:0] ext_adr;
    logic         donemult = 1'b0;
    logic         load, init0, sh, sel0, selpix, rd_inram, wr_inram;
    logic [M-1:0] pixadr, out_adr;
    logic         startmult, out_valid, busy, done, err;
    logic [23:0]  outs_s;

    int n_tests = 0;
    int n_fail  = 0;
    int mac_cnt = 0;
    bit mac_en  = 1'b1;

    conv_ctrl #(.m(M), .p(P), .TW(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .ext_wr(ext_wr), .ext_adr(ext_adr),
        .donemult(donemult), .load(load), .init0(init0), .sh(sh), .sel0(sel0),
        .selpix(selpix), .rd_inram(rd_inram), .wr_inram(wr_inram), .pixadr(pixadr),
        .startmult(startmult), .out_valid(out_valid), .out_adr(out_adr),
        .busy(busy), .done(done), .err(err)
    );

    assign outs_s = {load, init0, sh, sel0, selpix, rd_inram, wr_inram, pixadr,
                     startmult, out_valid, out_adr, busy, done, err};

    always #5 clk = ~clk;

    // MAC model: donemult is high for the third cycle after each startmult cycle.
    always @(negedge clk) begin
        if (!rst) begin
            mac_cnt  = 0;
            donemult = 1'b0;
        end else begin
            donemult = 1'b0;
            if (mac_cnt != 0) begin
                mac_cnt = mac_cnt - 1;
                if (mac_cnt == 0) donemult = mac_en;
            end
            if (startmult && mac_en) mac_cnt = 3;
        end
    end

    initial begin
        #500000;
        $display("FAIL tb_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one frame from a start at the current negedge (cycle 0) back to IDLE.
    task automatic run_frame(input string nm);
        int sh_n   = 0;
        int sel0_n = 0;
        int pix_n  = 0;
        int ov_n   = 0;
        int done_n = 0;
        bit fin    = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 1000 && !fin; cyc++) begin
            if (cyc == 5) begin
                ext_wr  = 1'b1;
                ext_adr = 6'd7;
                #1;
                chk({nm, "_stream_wr_blocked"}, int'(wr_inram), 0);
                ext_wr  = 1'b0;
                ext_adr = 6'd0;
            end
            if (cyc == 1) chk({nm, "_load_c1"}, int'(load), 1);
            if (cyc == 2) chk({nm, "_init0_c2"}, int'(init0), 1);
            if (cyc >= 3 && cyc <= 19) chk({nm, "_sh_c3_19"}, int'(sh), 1);
            if (cyc == 19) chk({nm, "_nomult_c19"}, int'(startmult), 0);
            if (cyc == 20) chk({nm, "_startmult_c20"}, int'(startmult), 1);
            if (sh) sh_n++;
            if (sh && sel0) sel0_n++;
            if (selpix) begin
                chk({nm, "_pixadr"}, int'(pixadr), pix_n);
                chk({nm, "_rd_inram"}, int'(rd_inram), 1);
                pix_n++;
            end
            if (out_valid) begin
                if (ov_n == 0) chk({nm, "_first_ov_cycle"}, cyc, 24);
                chk({nm, "_out_adr"}, int'(out_adr), ov_n);
                ov_n++;
            end
            if (done) begin
                done_n++;
                fin   = 1'b1;
                start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_frame_finished"}, int'(fin), 1);
        chk({nm, "_start_in_done_ignored"}, int'(busy), 0);
        chk({nm, "_sh_count"}, sh_n, 49);
        chk({nm, "_sel0_count"}, sel0_n, 24);
        chk({nm, "_pix_count"}, pix_n, 25);
        chk({nm, "_out_valid_count"}, ov_n, 25);
        chk({nm, "_done_count"}, done_n, 1);
        chk({nm, "_err_clear"}, int'(err), 0);
    endtask

    initial begin
        int sm_n;
        int guard;
        int done_cyc;
        int done_n;
        int err_n;
        rst     = 1'b0;
        start   = 1'b0;
        ext_wr  = 1'b0;
        ext_adr = 6'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(outs_s), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_quiet", int'(outs_s), 0);

        ext_wr  = 1'b1;
        ext_adr = 6'd7;
        #1;
        chk("idle_wr_inram", int'(wr_inram), 1);
        chk("idle_pixadr", int'(pixadr), 7);
        chk("idle_busy", int'(busy), 0);
        ext_wr  = 1'b0;
        ext_adr = 6'd0;
        @(negedge clk);

        run_frame("f1");

        // Frame abandoned by reset in the WAIT cycle of window 10.
        sm_n  = 0;
        guard = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (sm_n < 11 && guard < 1000) begin
            if (startmult) sm_n++;
            if (sm_n < 11) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("f2_reach_window10", sm_n, 11);
        @(negedge clk);
        chk("f2_wait_busy", int'(busy), 1);
        chk("f2_wait_quiet", int'(startmult | out_valid | sh), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("f2_reset_outputs", int'(outs_s), 0);
        @(negedge clk);
        rst = 1'b1;

        run_frame("f3");

        // MAC never answers.
        mac_en = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
        done_cyc = -1;
        for (int cyc = 1; cyc < 100 && done_cyc < 0; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                chk("to_err_at_done", int'(err), 1);
            end else begin
                @(negedge clk);
            end
        end
        chk("to_done_cycle", done_cyc, 36);
        @(negedge clk);
        chk("to_idle_after_done", int'(busy), 0);
        chk("to_err_sticky", int'(err), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("to_relaunch_load", int'(load), 1);
        chk("to_err_cleared_by_load", int'(err), 0);
`else
        done_cyc = 0;
        done_n   = 0;
        err_n    = 0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (done) done_n++;
            if (err) err_n++;
            @(negedge clk);
        end
        chk("nto_busy_held", int'(busy), 1);
        chk("nto_no_done", done_n, done_cyc);
        chk("nto_no_err", err_n, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("final_reset_outputs", int'(outs_s), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
